// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the producers, the round-robin arbiter and the FIFO write port.
// The arbiter takes the slave modport; the producer/FIFO side takes the master modport.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                          enable;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          grant_valid;
  logic [2:0]                    grant_id;
  logic [15:0]                   stall_cnt;
  logic [15:0]                   beat_cnt_total;

  modport master (
    output enable,
    output req_valid,
    output req_data,
    output fifo_full,
    input  req_ready,
    input  fifo_wr_en,
    input  fifo_data_in,
    input  grant_valid,
    input  grant_id,
    input  stall_cnt,
    input  beat_cnt_total
  );

  modport slave (
    input  enable,
    input  req_valid,
    input  req_data,
    input  fifo_full,
    output req_ready,
    output fifo_wr_en,
    output fifo_data_in,
    output grant_valid,
    output grant_id,
    output stall_cnt,
    output beat_cnt_total
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers, bounded bursts.
// Optional stall/beat statistics counters are built when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4
) (
  input logic              ACLK,
  input logic              ARESETn,
  fifo_wr_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e                r_state, w_state_nxt;
  logic [2:0]            r_grant_id, w_grant_id_nxt;
  logic [3:0]            r_beat, w_beat_nxt;

  logic                  w_own_valid;
  logic [DATA_WIDTH-1:0] w_own_data;
  logic                  w_found;
  logic [2:0]            w_sel;
  int unsigned           w_idx;

  logic [NUM_REQ-1:0]    w_ready;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_grant_valid;

  // Current owner's valid and data slice.
  always_comb begin
    w_own_valid = 1'b0;
    w_own_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == 3'(i)) begin
        w_own_valid = bus.req_valid[i];
        w_own_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // First valid requester after the last owner, wrapping modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_grant_id;
    w_idx   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = 32'(r_grant_id) + k;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!w_found && (j == w_idx) && bus.req_valid[j]) begin
          w_found = 1'b1;
          w_sel   = 3'(j);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_id_nxt = r_grant_id;
    w_beat_nxt     = r_beat;
    w_ready        = '0;
    w_wr_en        = 1'b0;
    w_data         = '0;
    w_grant_valid  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.enable && w_found) begin
          w_state_nxt    = StGrant;
          w_grant_id_nxt = w_sel;
          w_beat_nxt     = 4'd0;
        end
      end
      StGrant: begin
        w_grant_valid = 1'b1;
        w_data        = w_own_data;
        // Ready never looks at valid, so producers see no combinational loop.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (r_grant_id == 3'(i)) begin
            w_ready[i] = bus.enable && !bus.fifo_full;
          end
        end
        w_wr_en = w_own_valid && bus.enable && !bus.fifo_full;
        if (!bus.enable || !w_own_valid) begin
          w_state_nxt = StIdle;
        end else if (w_wr_en) begin
          if (r_beat == 4'(BURST_LEN - 1)) begin
            w_state_nxt = StIdle;
          end else begin
            w_beat_nxt = r_beat + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= StIdle;
      r_grant_id <= 3'(NUM_REQ - 1);
      r_beat     <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_beat     <= w_beat_nxt;
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.fifo_wr_en   = w_wr_en;
  assign bus.fifo_data_in = w_data;
  assign bus.grant_valid  = w_grant_valid;
  assign bus.grant_id     = r_grant_id;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_beat_total;
  logic        w_stall;

  assign w_stall = (r_state == StGrant) && w_own_valid && bus.enable && bus.fifo_full;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_stall_cnt  <= 16'd0;
      r_beat_total <= 16'd0;
    end else begin
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_wr_en && (r_beat_total != 16'hFFFF)) begin
        r_beat_total <= r_beat_total + 16'd1;
      end
    end
  end

  assign bus.stall_cnt      = r_stall_cnt;
  assign bus.beat_cnt_total = r_beat_total;
`else
  assign bus.stall_cnt      = 16'd0;
  assign bus.beat_cnt_total = 16'd0;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single `wr_en`/`data_in` write port of the AXI CSR FIFO subsystem between `NUM_REQ` independent sample producers, such as multiple ECG acquisition channels. It sits between the producers and the FIFO write port, and is gated by the CSR CONTROL enable bit. It never issues a write while `fifo_full` is high. Bursts are bounded so that no producer can starve the others.

## Interface
- `NUM_REQ`, 2: number of requesters (2–8).
- `DATA_WIDTH`, 32: sample width.
- `BURST_LEN`, 4: maximum consecutive accepted beats per grant (1–16).
- `ACLK` input 1: system clock; all logic on rising edge.
- `ARESETn` input 1: asynchronous, active-low reset.
- `enable` input 1: CSR CONTROL[0]; arbiter grants only while high.
- `req_valid` input `NUM_REQ`: per-requester data valid.
- `req_data` input `NUM_REQ*DATA_WIDTH`: packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready` output `NUM_REQ`: per-requester accept; a beat transfers when valid && ready.
- `fifo_full` input 1: FIFO full flag.
- `fifo_wr_en` output 1: FIFO write strobe.
- `fifo_data_in` output `DATA_WIDTH`: FIFO write data.
- `grant_valid` output 1: high while a grant is held (state GRANT).
- `grant_id` output 3: current or last owner index.
- `stall_cnt` output 16: cycles a granted beat was blocked by `fifo_full` (see Configuration).
- `beat_cnt_total` output 16: total beats written (see Configuration).

## Operation
- States: IDLE, GRANT.
- IDLE:
  - If `enable` is high and any `req_valid` is high, select the first requester with valid set, searching from `grant_id+1` modulo `NUM_REQ` and wrapping.
  - Load `grant_id` with the selected index, clear `beat`, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - `req_ready[grant_id] = enable && !fifo_full`; all other `req_ready` bits are 0.
  - `fifo_wr_en = req_valid[grant_id] && req_ready[grant_id]`.
  - `fifo_data_in` = the `grant_id` slice of `req_data` (combinational mux).
- On each accepted beat, `beat` increments. Return to IDLE when any of the following holds:
  - an accepted beat has `beat == BURST_LEN-1`;
  - `req_valid[grant_id]` is low;
  - `enable` is low.
- `fifo_full` high in GRANT: hold the state and `beat`, drive ready low, and write nothing.
- `beat` is a 4-bit counter; it never exceeds `BURST_LEN-1`.
- Round-robin pointer: `grant_id` is retained through IDLE, so the next search always starts after the last owner.
- Reset values: state IDLE, `grant_id` = `NUM_REQ-1` (so requester 0 has first priority), `beat` = 0, `req_ready` = 0, `fifo_wr_en` = 0, `fifo_data_in` = 0 (mux output while in IDLE), `grant_valid` = 0, both counters 0.
- Reset asserted mid-burst: everything returns to reset values immediately. Producers must re-present their data.

## Timing
- Arbitration latency: 1 cycle. A request seen in IDLE at edge N allows its first write on cycle N+1 at the earliest.
- Owner switch costs one IDLE bubble cycle.
- Peak throughput: `BURST_LEN/(BURST_LEN+1)` writes per cycle.
- `fifo_wr_en` is combinational from registered state, `req_valid`, `enable` and `fifo_full`. The FIFO samples it at the next edge.
- `fifo_full` asserting in the same cycle forces `fifo_wr_en` low in that cycle.
- Handshake rules for producers:
  - Hold `req_valid` and data until ready.
  - `req_ready` may depend on `req_valid` only through the state transition, never combinationally.

## Configuration
- `FIFO_WR_ARB_STATS_EN` defined:
  - `stall_cnt` increments each GRANT cycle in which `req_valid[grant_id] && enable && fifo_full`.
  - `beat_cnt_total` increments on each `fifo_wr_en`.
  - Both counters saturate at 16'hFFFF and clear only on reset.
- `FIFO_WR_ARB_STATS_EN` undefined: both outputs are tied to 0 and no counter flops are inferred.

## Test plan
- Reset, enable=1, req0 streams 6 beats (0x10–0x15), req1 idle: writes 0x10–0x13, one bubble, then 0x14–0x15; `grant_id` stays 0.
- Both requesters continuously valid, `BURST_LEN`=4: the FIFO write sequence is 4 beats from req0, a bubble, 4 beats from req1, a bubble, then req0 again. No requester gets two consecutive bursts.
- `fifo_full` forced high for 5 cycles mid-burst after beat 2:
  - no `fifo_wr_en` during those cycles;
  - state stays GRANT;
  - `stall_cnt` = 5 with stats enabled;
  - burst resumes at beat 2 and completes 4 total.
- enable=0 while req0 and req1 are valid: `req_ready` = 0 and `fifo_wr_en` = 0 for 20 cycles. After enable=1, the first grant goes to req0.
- `ARESETn` pulsed low mid-burst after 2 beats:
  - outputs return to reset values asynchronously;
  - after release, the first grant goes to req0 and `beat_cnt_total` restarts from 0.
- `NUM_REQ`=3, only req2 valid, then req0 and req2 both valid: grant goes to req2, then req0, then req2. `grant_id` wraps 2→0.
